// File: rtl/cpu_host_seq.sv
// ---------------------------------------------------------------------------
// cpu_host_seq
//
// Host-transfer sequencer for the CPU top. It loads instruction memory and
// data memory from the host over the op/rd_valid/tx_done handshake, releases
// the pipeline, and once the CPU halts it copies a result window out of
// data memory back to the host.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ready             host image available (level start)
//   op                host command: 00 IDLE, 01 READ, 11 WRITE
//   host_addr         host byte address
//   host_rd_data      host read data, qualified by rd_valid
//   rd_valid          host read data valid (1-cycle pulse)
//   host_wrt_data     host write data
//   tx_done           host write accepted (1-cycle pulse)
//   im_wrt_*          instruction memory write port
//   dm_wrt_en/dm_rd_en/dm_addr/dm_wrt_data/dm_rd_data
//                     data memory port (read data one cycle after dm_rd_en)
//   cpu_halt          CPU finished (level)
//   cpu_init_stall    hold PC and inject NOPs (low only while running)
//   done              write-back complete
//   err               host transaction timed out (sticky until reset)
// ---------------------------------------------------------------------------
module cpu_host_seq #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 32,
    parameter int                IM_WORDS     = 256,
    parameter int                DM_WORDS     = 256,
    parameter int                WB_WORDS     = 16,
    parameter logic [ADDR_W-1:0] IM_HOST_BASE = 16'h0000,
    parameter logic [ADDR_W-1:0] DM_HOST_BASE = 16'h4000,
    parameter logic [ADDR_W-1:0] WB_DM_BASE   = 16'h0000,
    parameter logic [ADDR_W-1:0] WB_HOST_BASE = 16'h8000,
    parameter int                TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready,
    output logic [1:0]        op,
    output logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_rd_data,
    input  logic              rd_valid,
    output logic [DATA_W-1:0] host_wrt_data,
    input  logic              tx_done,
    output logic              im_wrt_en,
    output logic [ADDR_W-1:0] im_wrt_addr,
    output logic [DATA_W-1:0] im_wrt_data,
    output logic              dm_wrt_en,
    output logic              dm_rd_en,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wrt_data,
    input  logic [DATA_W-1:0] dm_rd_data,
    input  logic              cpu_halt,
    output logic              cpu_init_stall,
    output logic              done,
    output logic              err
);

    localparam int MAX_IM_DM = (IM_WORDS > DM_WORDS) ? IM_WORDS : DM_WORDS;
    localparam int MAX_WORDS = (MAX_IM_DM > WB_WORDS) ? MAX_IM_DM : WB_WORDS;
    localparam int IDX_W     = $clog2(MAX_WORDS) + 1;
    // +2 keeps the width >= 1 and large enough to hold TIMEOUT_CYC-1
    localparam int TCNT_W    = $clog2(TIMEOUT_CYC + 2);

    localparam logic [IDX_W-1:0]  IM_LAST   = IDX_W'(IM_WORDS - 1);
    localparam logic [IDX_W-1:0]  DM_LAST   = IDX_W'(DM_WORDS - 1);
    localparam logic [IDX_W-1:0]  WB_LAST   = IDX_W'(WB_WORDS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit                TO_EN     = (TIMEOUT_CYC != 0);

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_IM,
        S_INIT_DM,
        S_RUN,
        S_WB_RD,
        S_WB_CAP,
        S_WB_TX,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [DATA_W-1:0]   wb_buf_q, wb_buf_d;

    logic [ADDR_W-1:0]   idx_off;
    logic                timed_out;

    // Word index to byte offset; truncation gives modulo-2^ADDR_W wrap.
    assign idx_off   = ADDR_W'({idx_q, 2'b00});
    assign timed_out = TO_EN && (tcnt_q == TCNT_LAST);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tcnt_d   = tcnt_q;
        wb_buf_d = wb_buf_q;

        case (state_q)
            S_IDLE: begin
                if (ready) begin
                    state_d = S_INIT_IM;
                    idx_d   = '0;
                end
            end

            S_INIT_IM: begin
                // A handshake in the final timeout cycle still wins.
                if (rd_valid) begin
                    tcnt_d = '0;
                    if (idx_q == IM_LAST) begin
                        state_d = S_INIT_DM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            S_INIT_DM: begin
                if (rd_valid) begin
                    tcnt_d = '0;
                    if (idx_q == DM_LAST) begin
                        state_d = S_RUN;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            S_RUN: begin
                if (cpu_halt) begin
                    state_d = S_WB_RD;
                    idx_d   = '0;
                end
            end

            S_WB_RD: state_d = S_WB_CAP;

            S_WB_CAP: begin
                wb_buf_d = dm_rd_data;
                state_d  = S_WB_TX;
            end

            S_WB_TX: begin
                if (tx_done) begin
                    tcnt_d = '0;
                    idx_d  = idx_q + 1'b1;
                    state_d = (idx_q == WB_LAST) ? S_DONE : S_WB_RD;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            S_DONE: begin
                if (!ready) state_d = S_IDLE;
            end

            S_ERR: state_d = S_ERR;

            default: state_d = S_IDLE;
        endcase

        // Every transaction starts its timeout window fresh.
        if (state_d != state_q) tcnt_d = '0;
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from the registered state so that an asynchronous
    // reset forces them to their idle values immediately. Memory strobes
    // follow the host handshake within the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        op             = OP_IDLE;
        host_addr      = '0;
        host_wrt_data  = '0;
        im_wrt_en      = 1'b0;
        im_wrt_addr    = '0;
        im_wrt_data    = '0;
        dm_wrt_en      = 1'b0;
        dm_rd_en       = 1'b0;
        dm_addr        = '0;
        dm_wrt_data    = '0;
        cpu_init_stall = 1'b1;
        done           = 1'b0;
        err            = 1'b0;

        case (state_q)
            S_INIT_IM: begin
                op          = OP_READ;
                host_addr   = IM_HOST_BASE + idx_off;
                im_wrt_en   = rd_valid;
                im_wrt_addr = idx_off;
                im_wrt_data = host_rd_data;
            end
            S_INIT_DM: begin
                op          = OP_READ;
                host_addr   = DM_HOST_BASE + idx_off;
                dm_wrt_en   = rd_valid;
                dm_addr     = idx_off;
                dm_wrt_data = host_rd_data;
            end
            S_RUN: begin
                cpu_init_stall = 1'b0;
            end
            S_WB_RD: begin
                dm_rd_en = 1'b1;
                dm_addr  = WB_DM_BASE + idx_off;
            end
            S_WB_TX: begin
                op            = OP_WRITE;
                host_addr     = WB_HOST_BASE + idx_off;
                host_wrt_data = wb_buf_q;
            end
            S_DONE: done = 1'b1;
            S_ERR:  err  = 1'b1;
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tcnt_q   <= '0;
            wb_buf_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tcnt_q   <= tcnt_d;
            wb_buf_q <= wb_buf_d;
        end
    end

endmodule

// File: tb/tb_cpu_host_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_host_seq
//
// Directed bench for cpu_host_seq with small region sizes (4 IM words,
// 4 DM words, 2 write-back words) and an 8-cycle transaction timeout.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// A small behavioural data memory backs the DM port.
// ---------------------------------------------------------------------------
module tb_cpu_host_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b0;
    logic [1:0]  op;
    logic [15:0] host_addr;
    logic [31:0] host_rd_data = '0;
    logic        rd_valid = 1'b0;
    logic [31:0] host_wrt_data;
    logic        tx_done = 1'b0;
    logic        im_wrt_en;
    logic [15:0] im_wrt_addr;
    logic [31:0] im_wrt_data;
    logic        dm_wrt_en;
    logic        dm_rd_en;
    logic [15:0] dm_addr;
    logic [31:0] dm_wrt_data;
    logic [31:0] dm_rd_data = '0;
    logic        cpu_halt = 1'b0;
    logic        cpu_init_stall;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    cpu_host_seq #(
        .ADDR_W      (16),
        .DATA_W      (32),
        .IM_WORDS    (4),
        .DM_WORDS    (4),
        .WB_WORDS    (2),
        .IM_HOST_BASE(16'h0000),
        .DM_HOST_BASE(16'h4000),
        .WB_DM_BASE  (16'h0000),
        .WB_HOST_BASE(16'h8000),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ready         (ready),
        .op            (op),
        .host_addr     (host_addr),
        .host_rd_data  (host_rd_data),
        .rd_valid      (rd_valid),
        .host_wrt_data (host_wrt_data),
        .tx_done       (tx_done),
        .im_wrt_en     (im_wrt_en),
        .im_wrt_addr   (im_wrt_addr),
        .im_wrt_data   (im_wrt_data),
        .dm_wrt_en     (dm_wrt_en),
        .dm_rd_en      (dm_rd_en),
        .dm_addr       (dm_addr),
        .dm_wrt_data   (dm_wrt_data),
        .dm_rd_data    (dm_rd_data),
        .cpu_halt      (cpu_halt),
        .cpu_init_stall(cpu_init_stall),
        .done          (done),
        .err           (err)
    );

    // Behavioural data memory: synchronous write, one-cycle read latency.
    logic [31:0] dm_mem [0:63];
    always @(posedge clk) begin
        if (dm_wrt_en) dm_mem[dm_addr[7:2]] <= dm_wrt_data;
        if (dm_rd_en)  dm_rd_data <= dm_mem[dm_addr[7:2]];
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] dm_img [0:3];
    logic [31:0] wb_exp [0:1];

    initial begin
        dm_img[0] = 32'hDEADBEEF;
        dm_img[1] = 32'h12345678;
        dm_img[2] = 32'h00000055;
        dm_img[3] = 32'h00000066;
        wb_exp[0] = 32'hDEADBEEF;
        wb_exp[1] = 32'h12345678;

        // ---------------- reset values ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_op",    32'(op), 32'h0);
        chk("rst_stall", 32'(cpu_init_stall), 32'h1);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        chk("rst_imwe",  32'(im_wrt_en), 32'h0);
        chk("rst_haddr", 32'(host_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- stray pulses in IDLE ----------------
        @(negedge clk);
        rd_valid = 1'b1; tx_done = 1'b1; cpu_halt = 1'b1;
        #1;
        chk("idle_stray_imwe", 32'(im_wrt_en), 32'h0);
        chk("idle_stray_dmwe", 32'(dm_wrt_en), 32'h0);
        @(negedge clk);
        rd_valid = 1'b0; tx_done = 1'b0; cpu_halt = 1'b0;
        #1;
        chk("idle_stray_op", 32'(op), 32'h0);

        // ---------------- IM load, rd_valid one cycle after request ----
        @(negedge clk);
        ready = 1'b1;
        #1;
        chk("idle_before_start_op", 32'(op), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (i == 1) ready = 1'b0;   // ready dropping mid-load is ignored
            #1;
            chk($sformatf("im%0d_req_op", i), 32'(op), 32'h1);
            chk($sformatf("im%0d_req_addr", i), 32'(host_addr), 32'(i * 4));
            chk($sformatf("im%0d_req_we", i), 32'(im_wrt_en), 32'h0);
            @(negedge clk);
            rd_valid = 1'b1;
            host_rd_data = 32'hA0 + 32'(i);
            #1;
            chk($sformatf("im%0d_we", i), 32'(im_wrt_en), 32'h1);
            chk($sformatf("im%0d_waddr", i), 32'(im_wrt_addr), 32'(i * 4));
            chk($sformatf("im%0d_wdata", i), im_wrt_data, 32'hA0 + 32'(i));
            chk($sformatf("im%0d_op", i), 32'(op), 32'h1);
        end

        // ---------------- DM load, back-to-back rd_valid ----------------
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd_valid = 1'b1;
            host_rd_data = dm_img[i];
            #1;
            chk($sformatf("dm%0d_op", i), 32'(op), 32'h1);
            chk($sformatf("dm%0d_haddr", i), 32'(host_addr), 32'h4000 + 32'(i * 4));
            chk($sformatf("dm%0d_we", i), 32'(dm_wrt_en), 32'h1);
            chk($sformatf("dm%0d_addr", i), 32'(dm_addr), 32'(i * 4));
            chk($sformatf("dm%0d_stall", i), 32'(cpu_init_stall), 32'h1);
        end

        // ---------------- RUN ----------------
        @(negedge clk);
        rd_valid = 1'b0;
        #1;
        chk("run_stall", 32'(cpu_init_stall), 32'h0);
        chk("run_op", 32'(op), 32'h0);
        @(negedge clk);
        rd_valid = 1'b1; tx_done = 1'b1;
        #1;
        chk("run_stray_imwe", 32'(im_wrt_en), 32'h0);
        chk("run_stray_dmwe", 32'(dm_wrt_en), 32'h0);
        @(negedge clk);
        rd_valid = 1'b0; tx_done = 1'b0;
        #1;
        chk("run_stray_stall", 32'(cpu_init_stall), 32'h0);
        @(negedge clk);
        cpu_halt = 1'b1;
        #1;
        chk("run_halt_stall", 32'(cpu_init_stall), 32'h0);

        // ---------------- write-back, tx_done on third WB_TX cycle ------
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            cpu_halt = 1'b0; tx_done = 1'b0;
            #1;
            chk($sformatf("wb%0d_rd_en", w), 32'(dm_rd_en), 32'h1);
            chk($sformatf("wb%0d_rd_addr", w), 32'(dm_addr), 32'(w * 4));
            chk($sformatf("wb%0d_rd_stall", w), 32'(cpu_init_stall), 32'h1);
            chk($sformatf("wb%0d_rd_op", w), 32'(op), 32'h0);
            @(negedge clk);
            #1;
            chk($sformatf("wb%0d_cap_op", w), 32'(op), 32'h0);
            chk($sformatf("wb%0d_cap_rd_en", w), 32'(dm_rd_en), 32'h0);
            @(negedge clk);
            #1;
            chk($sformatf("wb%0d_tx_op", w), 32'(op), 32'h3);
            chk($sformatf("wb%0d_tx_addr", w), 32'(host_addr), 32'h8000 + 32'(w * 4));
            chk($sformatf("wb%0d_tx_data", w), host_wrt_data, wb_exp[w]);
            @(negedge clk);
            #1;
            chk($sformatf("wb%0d_tx_hold", w), 32'(op), 32'h3);
            @(negedge clk);
            tx_done = 1'b1;
            #1;
            chk($sformatf("wb%0d_tx_last_op", w), 32'(op), 32'h3);
            chk($sformatf("wb%0d_tx_last_data", w), host_wrt_data, wb_exp[w]);
        end
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("done_flag", 32'(done), 32'h1);
        chk("done_stall", 32'(cpu_init_stall), 32'h1);
        chk("done_op", 32'(op), 32'h0);
        @(negedge clk);
        #1;
        chk("back_idle_done", 32'(done), 32'h0);
        chk("back_idle_op", 32'(op), 32'h0);

        // ---------------- timeout: rd_valid withheld ----------------
        @(negedge clk);
        ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_wait%0d_err", k), 32'(err), 32'h0);
            chk($sformatf("to_wait%0d_op", k), 32'(op), 32'h1);
        end
        @(negedge clk);
        #1;
        chk("to_err", 32'(err), 32'h1);
        chk("to_err_op", 32'(op), 32'h0);
        chk("to_err_stall", 32'(cpu_init_stall), 32'h1);
        @(negedge clk);
        rd_valid = 1'b1;
        #1;
        chk("err_stray_imwe", 32'(im_wrt_en), 32'h0);
        chk("err_sticky", 32'(err), 32'h1);

        // ---------------- handshake exactly at tcnt=7 wins ----------------
        @(negedge clk);
        rd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst2_err", 32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            cpu_halt = (k == 3);        // halt is ignored while loading
            #1;
            chk($sformatf("win_wait%0d_err", k), 32'(err), 32'h0);
            chk($sformatf("win_wait%0d_op", k), 32'(op), 32'h1);
            chk($sformatf("win_wait%0d_addr", k), 32'(host_addr), 32'h0);
        end
        @(negedge clk);
        cpu_halt = 1'b0;
        rd_valid = 1'b1;
        host_rd_data = 32'hB0;
        #1;
        chk("win_imwe", 32'(im_wrt_en), 32'h1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            host_rd_data = 32'hB0 + 32'(i);
            #1;
            chk($sformatf("b2b%0d_err", i), 32'(err), 32'h0);
            chk($sformatf("b2b%0d_op", i), 32'(op), 32'h1);
            chk($sformatf("b2b%0d_haddr", i), 32'(host_addr), 32'(i * 4));
            chk($sformatf("b2b%0d_we", i), 32'(im_wrt_en), 32'h1);
            chk($sformatf("b2b%0d_waddr", i), 32'(im_wrt_addr), 32'(i * 4));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("dm2_%0d_we", i), 32'(dm_wrt_en), 32'h1);
            chk($sformatf("dm2_%0d_addr", i), 32'(dm_addr), 32'(i * 4));
            chk($sformatf("dm2_%0d_haddr", i), 32'(host_addr), 32'h4000 + 32'(i * 4));
        end

        // ---------------- asynchronous reset mid-INIT_DM (idx=3) ----------
        @(negedge clk);
        #1;
        chk("mid_dm_haddr", 32'(host_addr), 32'h400C);
        chk("mid_dm_we", 32'(dm_wrt_en), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_op", 32'(op), 32'h0);
        chk("async_rst_dmwe", 32'(dm_wrt_en), 32'h0);
        chk("async_rst_haddr", 32'(host_addr), 32'h0);
        chk("async_rst_stall", 32'(cpu_init_stall), 32'h1);
        @(negedge clk);
        rd_valid = 1'b0;
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        rd_valid = 1'b1;
        host_rd_data = 32'hC0;
        #1;
        chk("restart_op", 32'(op), 32'h1);
        chk("restart_haddr", 32'(host_addr), 32'h0);
        chk("restart_imwe", 32'(im_wrt_en), 32'h1);
        chk("restart_waddr", 32'(im_wrt_addr), 32'h0);
        chk("restart_wdata", im_wrt_data, 32'hC0);
        @(negedge clk);
        rd_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cpu_host_seq.md
Name: cpu_host_seq

Overview:
Parametrised host-transfer sequencer for the CPU top. It loads instruction memory and data memory from the host over the op/rd_valid/tx_done memory-controller handshake, then releases the pipeline. When the CPU halts it reads back a result window from data memory and writes it to the host. Compared with the previous fixed init sequence, it adds configurable region sizes and base addresses, a per-transaction timeout with a sticky error, and a write-back phase.

Parameters:
ADDR_W, 16, address width on host, IM and DM buses (byte addresses)
DATA_W, 32, word width
IM_WORDS, 256, words loaded into IM (>=1)
DM_WORDS, 256, words loaded into DM (>=1)
WB_WORDS, 16, words written back to host (>=1)
IM_HOST_BASE, 16'h0000, host byte address of the IM image
DM_HOST_BASE, 16'h4000, host byte address of the DM image
WB_DM_BASE, 16'h0000, DM byte address of the result window
WB_HOST_BASE, 16'h8000, host byte address for results
TIMEOUT_CYC, 1024, cycles allowed per host transaction; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ready  in  1  host image available; level-sensitive start
op  out  2  host command: 00 IDLE, 01 READ, 11 WRITE (10 never driven)
host_addr  out  ADDR_W  host byte address
host_rd_data  in  DATA_W  host read data, valid with rd_valid
rd_valid  in  1  host read data valid (1-cycle pulse)
host_wrt_data  out  DATA_W  host write data
tx_done  in  1  host write accepted (1-cycle pulse)
im_wrt_en  out  1  IM write strobe
im_wrt_addr  out  ADDR_W  IM byte address
im_wrt_data  out  DATA_W  IM write data
dm_wrt_en  out  1  DM write strobe
dm_rd_en  out  1  DM read strobe
dm_addr  out  ADDR_W  DM byte address
dm_wrt_data  out  DATA_W  DM write data
dm_rd_data  in  DATA_W  DM read data, 1 cycle after dm_rd_en
cpu_halt  in  1  CPU finished (level)
cpu_init_stall  out  1  hold PC and inject NOPs
done  out  1  write-back complete
err  out  1  host timeout occurred (sticky)

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counters=0; op=00, all strobes 0, addresses/data 0, cpu_init_stall=1, done=0, err=0.
- Registers:
  - idx: word index, width clog2(max words)+1.
  - tcnt: timeout counter.
  - wb_buf: DATA_W write-back buffer.
- Address generation: byte address = base + (idx<<2), truncated to ADDR_W (wraps modulo 2^ADDR_W).
- States:
  - IDLE: stall=1. Go to INIT_IM with idx=0 when ready=1.
  - INIT_IM: op=01, host_addr=IM_HOST_BASE+(idx<<2). On rd_valid, in the same cycle:
    - im_wrt_en=1, im_wrt_addr=idx<<2, im_wrt_data=host_rd_data.
    - idx++ and tcnt cleared.
    - After word IM_WORDS-1, go to INIT_DM with idx=0.
    - op stays 01 continuously until the last word is accepted.
  - INIT_DM: same as INIT_IM, but writes DM (dm_wrt_en, dm_addr=idx<<2) from DM_HOST_BASE. After DM_WORDS words, go to RUN.
  - RUN: cpu_init_stall=0, op=00. When cpu_halt=1, go to WB_RD with idx=0.
  - WB_RD: dm_rd_en=1, dm_addr=WB_DM_BASE+(idx<<2), op=00. Next state WB_CAP.
  - WB_CAP: latch dm_rd_data into wb_buf. Next state WB_TX.
  - WB_TX: op=11, host_addr=WB_HOST_BASE+(idx<<2), host_wrt_data=wb_buf, held until tx_done. On tx_done, idx++; after word WB_WORDS-1 go to DONE, else go to WB_RD.
  - DONE: done=1, stall=1, op=00. Go to IDLE when ready=0.
  - ERR: err=1, stall=1, op=00, all strobes 0. Leave only by reset.
- Stall output: cpu_init_stall=1 in every state except RUN. The timing is combinational from state; it is registered through state only.
- Timeout:
  - tcnt increments each cycle in INIT_IM, INIT_DM and WB_TX, and clears on rd_valid, on tx_done, and on every state change.
  - When tcnt reaches TIMEOUT_CYC-1 with no handshake that cycle, the next state is ERR.
  - A handshake arriving in that same cycle wins (no error).
  - TIMEOUT_CYC=0: no timeout.
- Stray inputs:
  - rd_valid is ignored outside INIT_IM/INIT_DM.
  - tx_done is ignored outside WB_TX.
  - cpu_halt is ignored outside RUN.
  - ready falling mid-load is ignored; the load completes.
- Write-back latency: each word costs 2 cycles plus the host tx_done latency. rd_valid on the first cycle of op=01 is accepted.
- Throughput: back-to-back rd_valid (every cycle) loads one word per cycle.

Test Plan:
- Reset then ready=1, IM_WORDS=4, host returns rd_valid one cycle after each request with data 32'hA0+idx:
  - IM writes to 0,4,8,C with A0..A3.
  - Then DM is loaded from 16'h4000.
  - cpu_init_stall falls in the cycle after the last DM word.
- Back-to-back rd_valid every cycle: one IM write per cycle; op never drops to 00 between words; the last word moves state to INIT_DM.
- RUN with cpu_halt=1, WB_WORDS=2, DM[0]=DEADBEEF, DM[4]=12345678, tx_done after 3 cycles:
  - Host writes DEADBEEF@8000, then 12345678@8004.
  - done=1 after the second tx_done.
  - cpu_init_stall=1 from the WB_RD entry onward.
- TIMEOUT_CYC=8, withhold rd_valid in INIT_IM: err=1 and op=00 on the cycle after tcnt=7. Also rd_valid exactly at tcnt=7 leaves err=0.
- Deassert rst_n mid-INIT_DM (idx=3): outputs go to reset values immediately (asynchronously). Re-raising ready restarts from IM idx=0.
- Stray rd_valid/tx_done pulses in IDLE and RUN, and cpu_halt during INIT_IM: no IM/DM writes, no state change.
